// File: rtl/riscv_pkg.sv
// Shared constants and the next-PC select encoding for the PC sequencer.
package riscv_pkg;

    localparam int          XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_HOLD,
        SEL_MISALIGN,
        SEL_REDIRECT,
        SEL_POP,
        SEL_SEQ
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full silently overwrites the
// oldest entry, and the top is always the slot just below the write pointer.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty,
    output logic            full
);

    localparam int               PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int               CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  entries [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_prev;
    logic [CNT_W-1:0] count;

    // Power-of-two depth lets the pointer wrap by plain overflow.
    assign ptr_prev = ptr - PTR_W'(1);
    assign top_data = entries[ptr_prev];
    assign empty    = (count == '0);
    assign full     = (count == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (!full) count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr_prev;
            count <= count - CNT_W'(1);
        end
    end

    // NOTE: entry storage is deliberately not reset; count gates every read,
    // so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) entries[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC select (trap, stall,
// redirect, return, sequential) with a return-address stack for call/ret.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT),
    parameter int              RAS_DEPTH    = 4,
    parameter int              STEP         = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            trap,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            ras_empty,
    output logic            ras_underflow,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] STEP_X = XLEN'(STEP);

    pc_sel_e         sel;
    logic            ras_push;
    logic            ras_pop;
    logic            underflow_set;
    logic [XLEN-1:0] ras_top;
    logic            ras_full;

    assign pc_next_seq = pc + STEP_X;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sel           = SEL_SEQ;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
        underflow_set = 1'b0;
        if (trap) begin
            sel = SEL_TRAP;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            sel = SEL_MISALIGN;
        end else if (redirect_valid) begin
            sel      = SEL_REDIRECT;
            ras_push = call;
        end else if (ret && !ras_empty) begin
            sel     = SEL_POP;
            ras_pop = 1'b1;
        end else begin
            sel           = SEL_SEQ;
            underflow_set = ret;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc            <= RESET_VECTOR;
            ras_underflow <= 1'b0;
            misalign_err  <= 1'b0;
        end else begin
            ras_underflow <= underflow_set;
            misalign_err  <= (sel == SEL_MISALIGN);
            case (sel)
                SEL_TRAP,
                SEL_MISALIGN: pc <= TRAP_VECTOR;
                SEL_REDIRECT: pc <= redirect_target;
                SEL_POP:      pc <= ras_top;
                SEL_SEQ:      pc <= pc_next_seq;
                default:      pc <= pc;
            endcase
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_next_seq),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run against a queue-based reference model of the next-PC rules.
module tb_pc_sequencer;

    localparam logic [31:0] TRAP  = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        trap = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        ras_empty;
    logic        ras_underflow;
    logic        misalign_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_uf;
    logic        m_mis;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .trap            (trap),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call            (call),
        .ret             (ret),
        .pc              (pc),
        .pc_next_seq     (pc_next_seq),
        .ras_empty       (ras_empty),
        .ras_underflow   (ras_underflow),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc  = 32'h0;
        m_ras.delete();
        m_uf  = 1'b0;
        m_mis = 1'b0;
    endtask

    // Reference: the spec's priority list applied to a bounded queue.
    task automatic model_step();
        m_uf  = 1'b0;
        m_mis = 1'b0;
        if (trap) begin
            m_pc = TRAP;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (redirect_valid && (redirect_target % 4) != 0) begin
            m_pc  = TRAP;
            m_mis = 1'b1;
        end else if (redirect_valid) begin
            if (call) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc = redirect_target;
        end else if (ret && m_ras.size() > 0) begin
            m_pc = m_ras.pop_back();
        end else begin
            m_uf = ret;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic drive(input logic s, input logic t, input logic rv,
                         input logic [31:0] tg, input logic c, input logic r);
        stall           = s;
        trap            = t;
        redirect_valid  = rv;
        redirect_target = tg;
        call            = c;
        ret             = r;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Called at posedge+1; applies current inputs across one edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Reset spanning one edge; leaves the bench at posedge+1 with pc=0.
    task automatic do_reset();
        idle();
        reset = 1'b0;
        model_reset();
        #10;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        #2;
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_tests++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
        n_tests++; if ({ras_underflow, misalign_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {ras_underflow, misalign_err}); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle();
        cycle();
        n_tests++; if (pc !== 32'h8) begin n_fail++; $display("FAIL pre_reset_pc: got %h want %h", pc, 32'h8); end
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL async_reset_pc: got %h want %h", pc, 32'h0); end
        #9;
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            n_tests++; if (pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc_%0d: got %h want %h", i, pc, 32'(4 * i)); end
        end
        n_tests++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL seq_empty: got %b want 1", ras_empty); end
    endtask

    task automatic test_branch_misalign();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
        cycle();
        n_tests++; if (pc !== 32'h40) begin n_fail++; $display("FAIL branch_pc: got %h want %h", pc, 32'h40); end
        idle();
        cycle();
        n_tests++; if (pc !== 32'h44) begin n_fail++; $display("FAIL branch_seq: got %h want %h", pc, 32'h44); end
        drive(1'b0, 1'b0, 1'b1, 32'h42, 1'b1, 1'b0);
        cycle();
        n_tests++; if (pc !== TRAP) begin n_fail++; $display("FAIL misalign_pc: got %h want %h", pc, TRAP); end
        n_tests++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_pulse: got %b want 1", misalign_err); end
        n_tests++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL misalign_nopush: got %b want 1", ras_empty); end
        idle();
        cycle();
        n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b want 0", misalign_err); end
        n_tests++; if (pc !== 32'h104) begin n_fail++; $display("FAIL misalign_seq: got %h want %h", pc, 32'h104); end
    endtask

    task automatic test_reset_pulse();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h81, 1'b0, 1'b0);
        cycle();
        n_tests++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL pulse_set: got %b want 1", misalign_err); end
        idle();
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL pulse_reset_clear: got %b want 0", misalign_err); end
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL pulse_reset_pc: got %h want %h", pc, 32'h0); end
        #6;
        reset = 1'b1;
    endtask

    task automatic test_call_return();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        cycle();
        n_tests++; if (pc !== 32'h200) begin n_fail++; $display("FAIL call1_pc: got %h want %h", pc, 32'h200); end
        n_tests++; if (ras_empty !== 1'b0) begin n_fail++; $display("FAIL call1_empty: got %b want 0", ras_empty); end
        drive(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
        cycle();
        n_tests++; if (pc !== 32'h300) begin n_fail++; $display("FAIL call2_pc: got %h want %h", pc, 32'h300); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle();
        n_tests++; if (pc !== 32'h204) begin n_fail++; $display("FAIL ret1_pc: got %h want %h", pc, 32'h204); end
        cycle();
        n_tests++; if (pc !== 32'h14) begin n_fail++; $display("FAIL ret2_pc: got %h want %h", pc, 32'h14); end
        n_tests++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ret2_empty: got %b want 1", ras_empty); end
        idle();
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h404;
        exp_ret[1] = 32'h304;
        exp_ret[2] = 32'h204;
        exp_ret[3] = 32'h104;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'(i * 32'h100), 1'b1, 1'b0);
            cycle();
        end
        n_tests++; if (pc !== 32'h500) begin n_fail++; $display("FAIL ovf_pc: got %h want %h", pc, 32'h500); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_tests++; if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL ovf_ret_%0d: got %h want %h", i, pc, exp_ret[i]); end
            n_tests++; if (ras_underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_uf_%0d: got %b want 0", i, ras_underflow); end
        end
        n_tests++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty: got %b want 1", ras_empty); end
        cycle();
        n_tests++; if (pc !== 32'h108) begin n_fail++; $display("FAIL uf_pc: got %h want %h", pc, 32'h108); end
        n_tests++; if (ras_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_pulse: got %b want 1", ras_underflow); end
        idle();
        cycle();
        n_tests++; if (ras_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %b want 0", ras_underflow); end
        n_tests++; if (pc !== 32'h10c) begin n_fail++; $display("FAIL uf_seq: got %h want %h", pc, 32'h10c); end
    endtask

    task automatic test_stall_trap();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive(1'b1, 1'b0, 1'b1, 32'h600, 1'b1, 1'b1);
            else        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            cycle();
            n_tests++; if (pc !== 32'h20) begin n_fail++; $display("FAIL stall_pc_%0d: got %h want %h", i, pc, 32'h20); end
        end
        n_tests++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL stall_nopush: got %b want 1", ras_empty); end
        idle();
        cycle();
        n_tests++; if (pc !== 32'h24) begin n_fail++; $display("FAIL stall_release: got %h want %h", pc, 32'h24); end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle();
        n_tests++; if (pc !== TRAP) begin n_fail++; $display("FAIL stall_trap: got %h want %h", pc, TRAP); end
        idle();
    endtask

    task automatic test_wrap_collision();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        cycle();
        idle();
        #1;
        n_tests++; if (pc_next_seq !== 32'h0) begin n_fail++; $display("FAIL wrap_next_seq: got %h want %h", pc_next_seq, 32'h0); end
        cycle();
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
        drive(1'b0, 1'b0, 1'b1, 32'h800, 1'b1, 1'b1);
        cycle();
        n_tests++; if (pc !== 32'h800) begin n_fail++; $display("FAIL collide_pc: got %h want %h", pc, 32'h800); end
        n_tests++; if (ras_empty !== 1'b0) begin n_fail++; $display("FAIL collide_push: got %b want 0", ras_empty); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle();
        n_tests++; if (pc !== 32'h4) begin n_fail++; $display("FAIL collide_ret: got %h want %h", pc, 32'h4); end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] tg;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            tg = {20'h0, 12'($urandom)};
            if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) == 0, tg,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            cycle();
            n_tests++; if (pc !== m_pc) begin n_fail++; $display("FAIL rand_pc_%0d: got %h want %h", i, pc, m_pc); end
            n_tests++; if (pc_next_seq !== m_pc + 32'd4) begin n_fail++; $display("FAIL rand_next_%0d: got %h want %h", i, pc_next_seq, m_pc + 32'd4); end
            n_tests++; if (ras_empty !== (m_ras.size() == 0)) begin n_fail++; $display("FAIL rand_empty_%0d: got %b want %b", i, ras_empty, m_ras.size() == 0); end
            n_tests++; if (ras_underflow !== m_uf) begin n_fail++; $display("FAIL rand_uf_%0d: got %b want %b", i, ras_underflow, m_uf); end
            n_tests++; if (misalign_err !== m_mis) begin n_fail++; $display("FAIL rand_mis_%0d: got %b want %b", i, misalign_err, m_mis); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_branch_misalign();
        test_reset_pulse();
        test_call_return();
        test_ras_overflow();
        test_stall_trap();
        test_wrap_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter block for the RISC core.
- Replaces the fixed 32-bit PC register with a unit that has configurable width and reset/trap vectors.
- Adds stall, trap, redirect (branch/jump) and a circular return-address stack (RAS) for call/return.
- Drives the instruction-fetch address; PC is consumed by instruction memory and the top-level debug output.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect.
- RAS_DEPTH, 4, number of return-address entries; power of two, minimum 2.
- STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC; ignored when trap is asserted.
- trap  input  1  force PC to TRAP_VECTOR.
- redirect_valid  input  1  take redirect_target (branch/jump).
- redirect_target  input  XLEN  jump/branch destination.
- call  input  1  valid only with redirect_valid; push PC+STEP onto the RAS.
- ret  input  1  pop the RAS top into PC.
- pc  output  XLEN  current fetch address.
- pc_next_seq  output  XLEN  combinational pc+STEP, wrapping modulo 2^XLEN.
- ras_empty  output  1  RAS occupancy is 0.
- ras_underflow  output  1  one-cycle pulse: ret issued while empty.
- misalign_err  output  1  one-cycle pulse: redirect target misaligned.

Behaviour:
- Reset is asserted asynchronously and released on a clock edge. While reset is low:
  - pc=RESET_VECTOR.
  - RAS pointer=0, count=0, ras_empty=1.
  - ras_underflow=0, misalign_err=0.
  - RAS entry contents are don't-care.
- Register update happens on every rising edge once reset is high. Next-PC priority, highest first:
  1. trap -> TRAP_VECTOR; no RAS change; stall ignored.
  2. stall -> pc holds; RAS unchanged; call, ret and redirect are dropped (not queued).
  3. redirect_valid with redirect_target[1:0]!=0 -> TRAP_VECTOR; misalign_err=1 next cycle; no push.
  4. redirect_valid -> redirect_target; if call is also asserted, push pc+STEP.
  5. ret with count>0 -> pop the top entry into pc.
  6. ret with count==0 -> pc+STEP; ras_underflow=1 next cycle.
  7. Otherwise -> pc+STEP.
- Latency: every change to pc is visible the cycle after the qualifying edge. pc_next_seq is purely combinational.
- Wrap-around: pc+STEP wraps modulo 2^XLEN, with no flag.
- RAS push:
  - Write to entry[ptr]; ptr<=ptr+1 modulo RAS_DEPTH; count<=min(count+1, RAS_DEPTH).
  - When full, a push silently overwrites the oldest entry (circular). count stays at RAS_DEPTH.
- RAS pop:
  - ptr<=ptr-1 modulo RAS_DEPTH; PC<=entry[ptr-1]; count<=count-1.
- call+ret in the same cycle: call wins (push plus redirect); ret is ignored.
- call without redirect_valid is ignored.
- ras_underflow and misalign_err are registered single-cycle pulses, cleared the following cycle unless re-triggered.
- Reset asserted mid-operation immediately forces all reset values, including clearing any pending pulse.

Decomposition:
- Shared package riscv_pkg:
  - XLEN default.
  - RESET_VECTOR and TRAP_VECTOR constants.
  - Next-PC select enum: SEL_TRAP, SEL_HOLD, SEL_MISALIGN, SEL_REDIRECT, SEL_POP, SEL_SEQ.
- Sub-module pc_ras: circular stack with ptr/count logic, push/pop/empty/full ports, parametrised by XLEN and RAS_DEPTH.
- pc_sequencer holds the PC register, the priority mux and the pulse flops.

Test Plan:
- Reset: hold reset=0 for 10 ns mid-cycle, release -> pc=0 asynchronously. Then 3 free edges -> pc=4, 8, 12; ras_empty=1.
- Branch and misalign:
  - redirect_valid=1, target=0x40 -> pc=0x40, next edge 0x44.
  - target=0x42 -> pc=0x100; misalign_err high for exactly one cycle.
- Call/return nesting: at pc=0x10, call+redirect to 0x200; at 0x200, call+redirect to 0x300.
  - ret -> pc=0x204.
  - ret -> pc=0x14.
  - ras_empty=1 afterwards.
- RAS overflow (RAS_DEPTH=4): 5 calls from pc 0x0, 0x100, 0x200, 0x300, 0x400.
  - 4 rets -> 0x404, 0x304, 0x204, 0x104.
  - 5th ret -> pc+4 with ras_underflow pulse.
- Stall vs trap:
  - stall=1 for 3 cycles at pc=0x20 -> pc stays 0x20; a redirect during the stall is dropped.
  - stall=1 with trap=1 -> pc=0x100.
- Wrap and collision (XLEN=32):
  - pc=0xFFFF_FFFC, no event -> pc=0x0000_0000.
  - call+ret together -> push happens, pc=redirect_target.
